spike_sum_pipe: RTL and testbench
=================================

// Module: spike_sum_pipe
// PURPOSE
//  Parametrised, pipelined successor of the flat weighted-spike summer. Adds N_CH
//  weighted synaptic spikes plus the conductance-decay term into a membrane-voltage
//  increment. Uses a registered adder tree, a valid/ready handshake with backpressure,
//  a per-channel enable mask, output saturation and a saturation-event counter.
//  Sits between the synapse weighting stage and the neuron threshold/refractory logic.
// PARAMETERS
//  N_CH     8    number of weighted-spike input channels (>=1)
//  W        14   width of each spike, the decay term and the output sum (unsigned)
//  CNT_W    16   width of the saturation-event counter
//  Derived: OPS = N_CH+1, LVL = $clog2(OPS) (min 1), IW = W+$clog2(OPS), LAT = LVL+1
// PORTS
//  clk                  in   1         clock, rising edge
//  reset                in   1         asynchronous, active-low reset
//  i_clear              in   1         synchronous flush of pipeline valids and counter
//  i_valid              in   1         input operand set valid
//  o_ready              out  1         pipeline can accept (advance) this cycle
//  i_weighted_spikes    in   N_CH*W    channel k = bits [k*W +: W]
//  i_ch_mask            in   N_CH      1 = include channel k, 0 = treat as zero
//  i_cond_decay         in   W         conductance-decay operand, always included
//  o_valid              out  1         o_sum_voltage valid
//  i_ready              in   1         downstream accepts o_sum_voltage
//  o_sum_voltage        out  W         saturated sum
//  o_sat                out  1         this o_sum_voltage was clipped (qualified by o_valid)
//  o_sat_count          out  CNT_W     saturation events handed off since reset/clear
// BEHAVIOUR
//  - Reset (reset=0, async): all pipeline data/valid regs, o_valid, o_sum_voltage,
//    o_sat and o_sat_count go to 0. o_ready = 1 once reset is released.
//  - Advance enable: adv = !o_valid | i_ready. o_ready = adv (combinational).
//    A transfer into the pipe happens when i_valid & o_ready. A handoff out of the
//    pipe happens when o_valid & i_ready.
//  - When adv=1, every stage shifts one step. Stage 0 registers the masked operands
//    (channel k forced to 0 when i_ch_mask[k]=0) plus i_cond_decay, zero-extended to IW.
//    Stage s (1..LVL) registers pairwise sums of stage s-1. An odd operand passes
//    through unchanged.
//  - The valid bit travels with the data. A bubble (i_valid=0) propagates as valid=0.
//  - When adv=0, all stages hold. This is a global stall: no data is lost or duplicated.
//  - Latency: exactly LAT cycles from acceptance to o_valid when unstalled
//    (LAT = 5 for N_CH = 8). Throughput is 1 set per cycle when i_ready = 1.
//  - Arithmetic: the internal IW width cannot overflow. At the final stage, a sum
//    greater than 2^W-1 gives o_sum_voltage = 2^W-1 and o_sat = 1. Otherwise
//    o_sum_voltage = sum[W-1:0] and o_sat = 0.
//  - Output regs hold their value while o_valid & !i_ready (stable under backpressure).
//  - o_sat_count increments by 1 on each handoff with o_sat = 1. It saturates at
//    2^CNT_W-1 and does not wrap.
//  - i_clear=1 (sync): all valid bits and o_sat_count go to 0 on that edge. Data regs
//    may keep stale values. Transfers accepted in the same cycle are discarded, and
//    i_clear overrides a simultaneous counter increment.
//  - Reset asserted mid-operation drops all in-flight sets. No output appears for them.
// TESTING
//  1. N_CH=8,W=14: spikes all 100, mask 0xFF, decay 50, i_ready=1 -> o_valid exactly
//     5 cycles later, o_sum_voltage=850, o_sat=0.
//  2. Mask 0x0F, spikes k=0..7 -> value 10*(k+1), decay 0 -> sum 100. Mask 0x00,
//     decay 7 -> sum 7.
//  3. All spikes 16383, decay 16383 -> o_sum_voltage=16383, o_sat=1, o_sat_count 0->1.
//     Repeat 3 sets -> count 4. Force count to 2^CNT_W-1 -> stays there.
//  4. Stream 10 sets back-to-back with i_ready toggling 1,0,0,1,... -> all 10 sums
//     delivered in order, none lost or repeated, o_sum_voltage stable while stalled,
//     o_ready=0 only when o_valid & !i_ready.
//  5. Assert reset for 1 cycle with 3 sets in flight -> all outputs 0, no o_valid for
//     the dropped sets. The next accepted set appears after LAT cycles.
//  6. i_clear pulse with sets in flight and o_sat_count=3 -> o_valid=0 next cycle,
//     count=0. A set accepted 1 cycle later emerges normally.

Source files
------------

// File: rtl/spike_sum_if.sv
// Handshake and data bundle for the pipelined weighted-spike summer.
// The slave side is the summer. The master side is whoever feeds operands
// in and consumes the saturated voltage increment.
interface spike_sum_if #(
  parameter int N_CH  = 8,
  parameter int W     = 14,
  parameter int CNT_W = 16
);
  logic                 i_clear;
  logic                 i_valid;
  logic                 o_ready;
  logic [N_CH*W-1:0]    i_weighted_spikes;
  logic [N_CH-1:0]      i_ch_mask;
  logic [W-1:0]         i_cond_decay;
  logic                 o_valid;
  logic                 i_ready;
  logic [W-1:0]         o_sum_voltage;
  logic                 o_sat;
  logic [CNT_W-1:0]     o_sat_count;

  modport master (
    output i_clear, i_valid, i_weighted_spikes, i_ch_mask, i_cond_decay, i_ready,
    input  o_ready, o_valid, o_sum_voltage, o_sat, o_sat_count
  );

  modport slave (
    input  i_clear, i_valid, i_weighted_spikes, i_ch_mask, i_cond_decay, i_ready,
    output o_ready, o_valid, o_sum_voltage, o_sat, o_sat_count
  );
endinterface

// File: rtl/spike_sum_pipe.sv
// Pipelined weighted-spike summer: masked channel operands plus the
// conductance-decay term go through a registered binary adder tree, the
// final sum is clipped to W bits, and clipped handoffs are counted.
// A single advance enable stalls every stage together under backpressure.
module spike_sum_pipe #(
  parameter int N_CH  = 8,
  parameter int W     = 14,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  spike_sum_if.slave      bus
);
  localparam int OPS = N_CH + 1;
  localparam int LVL = ($clog2(OPS) < 1) ? 1 : $clog2(OPS);
  localparam int IW  = W + $clog2(OPS);
  localparam logic [W-1:0]     SUM_MAX = {W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Number of live operands at tree level s (level 0 = raw operands).
  function automatic int ops_at(input int s);
    ops_at = (OPS + (1 << s) - 1) >> s;
  endfunction

  logic              adv;
  logic [LVL:0]      vld_r;
  logic [IW-1:0]     total;
  logic              sat_s;
  logic              o_valid_r;
  logic [W-1:0]      o_sum_r;
  logic              o_sat_r;
  logic [CNT_W-1:0]  cnt_r;

  // The whole pipe moves only when the output slot is free or being taken.
  assign adv         = ~o_valid_r | bus.i_ready;
  assign bus.o_ready = adv;

  // Valid bits ride alongside the data; clear and reset drop everything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_r <= '0;
    end else if (bus.i_clear) begin
      vld_r <= '0;
    end else if (adv) begin
      vld_r <= {vld_r[LVL-1:0], bus.i_valid};
    end
  end

  for (genvar s = 0; s <= LVL; s++) begin : g_lvl
    localparam int N = ops_at(s);
    logic [IW-1:0] nxt   [N];
    logic [IW-1:0] sum_r [N];

    if (s == 0) begin : g_in
      for (genvar j = 0; j < N; j++) begin : g_op
        if (j < N_CH) begin : g_ch
          assign nxt[j] = bus.i_ch_mask[j]
                        ? {{(IW-W){1'b0}}, bus.i_weighted_spikes[j*W +: W]}
                        : {IW{1'b0}};
        end else begin : g_dec
          assign nxt[j] = {{(IW-W){1'b0}}, bus.i_cond_decay};
        end
      end
    end else begin : g_add
      localparam int NP = ops_at(s - 1);
      for (genvar j = 0; j < N; j++) begin : g_op
        if (2*j + 1 < NP) begin : g_pair
          assign nxt[j] = g_lvl[s-1].sum_r[2*j] + g_lvl[s-1].sum_r[2*j+1];
        end else begin : g_odd
          assign nxt[j] = g_lvl[s-1].sum_r[2*j];
        end
      end
    end

    // Register this tree level; data is not flushed by clear, only its valid bit.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int j = 0; j < N; j++) sum_r[j] <= '0;
      end else if (adv) begin
        for (int j = 0; j < N; j++) sum_r[j] <= nxt[j];
      end
    end
  end

  assign total = g_lvl[LVL].sum_r[0];
  assign sat_s = |total[IW-1:W];

  // Output slot: clip the tree result and hold it steady while downstream stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_valid_r <= 1'b0;
      o_sum_r   <= '0;
      o_sat_r   <= 1'b0;
    end else begin
      if (bus.i_clear) begin
        o_valid_r <= 1'b0;
      end else if (adv) begin
        o_valid_r <= vld_r[LVL];
      end
      if (adv) begin
        o_sum_r <= sat_s ? SUM_MAX : total[W-1:0];
        o_sat_r <= sat_s;
      end
    end
  end

  // Count clipped handoffs, sticking at all-ones; clear wins over an increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (bus.i_clear) begin
      cnt_r <= '0;
    end else if (o_valid_r && bus.i_ready && o_sat_r && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign bus.o_valid       = o_valid_r;
  assign bus.o_sum_voltage = o_sum_r;
  assign bus.o_sat         = o_sat_r;
  assign bus.o_sat_count   = cnt_r;
endmodule

// File: tb/tb_spike_sum_pipe.sv
// Scoreboard bench for spike_sum_pipe: the stimulus pushes hand-computed
// results as sets are accepted, and an independent monitor pops and compares
// them at every handoff, also tracking the saturation counter, ready and hold.
module tb_spike_sum_pipe;
  localparam int N_CH  = 8;
  localparam int W     = 14;
  localparam int CNT_W = 16;
  localparam int LAT   = 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rdy_mode = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W:0]       exp_q [$];
  logic [CNT_W-1:0] model_cnt = '0;

  always #5 clk = ~clk;

  spike_sum_if #(.N_CH(N_CH), .W(W), .CNT_W(CNT_W)) bus ();

  spike_sum_pipe #(.N_CH(N_CH), .W(W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [N_CH*W-1:0] mk_all(input logic [W-1:0] v);
    logic [N_CH*W-1:0] r;
    for (int k = 0; k < N_CH; k++) r[k*W +: W] = v;
    return r;
  endfunction

  // Present a set and wait until it is accepted; push its expected result then.
  task automatic drive_set(input logic [N_CH*W-1:0] sp, input logic [N_CH-1:0] m,
                           input logic [W-1:0] d, input logic [W-1:0] es, input logic esat);
    int guard = 0;
    bus.i_valid = 1'b1;
    bus.i_weighted_spikes = sp;
    bus.i_ch_mask = m;
    bus.i_cond_decay = d;
    forever begin
      @(negedge clk);
      if (bus.o_ready) begin
        exp_q.push_back({esat, es});
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 50) begin
        n_checks++;
        $display("FAIL accept_timeout: o_ready stuck at 0 for %0d cycles", guard);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    bus.i_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called right after an acceptance edge on an empty pipe: count edges to o_valid.
  task automatic measure_lat(input string name);
    int k = 0;
    bus.i_valid = 1'b0;
    while (!bus.o_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, 32'(k), 32'(LAT));
  endtask

  // Downstream readiness: always ready, or the 1,0,0 repeating pattern.
  initial begin : sink
    int ph = 0;
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode) begin
        bus.i_ready = (ph % 3 == 0);
        ph++;
      end else begin
        bus.i_ready = 1'b1;
        ph = 0;
      end
    end
  end

  // Monitor: compare every handoff against the scoreboard and track the counter.
  initial begin : monitor
    logic hold_p;
    logic [W-1:0] sum_p;
    logic sat_p;
    logic [W:0] e;
    hold_p = 1'b0;
    sum_p = '0;
    sat_p = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("reset_o_valid", 32'(bus.o_valid), 32'd0);
        chk("reset_o_sum", 32'(bus.o_sum_voltage), 32'd0);
        chk("reset_o_sat", 32'(bus.o_sat), 32'd0);
        chk("reset_o_sat_count", 32'(bus.o_sat_count), 32'd0);
        exp_q.delete();
        model_cnt = '0;
        hold_p = 1'b0;
      end else begin
        chk("o_ready", 32'(bus.o_ready), 32'(!bus.o_valid || bus.i_ready));
        chk("o_sat_count", 32'(bus.o_sat_count), 32'(model_cnt));
        if (hold_p) begin
          chk("hold_valid", 32'(bus.o_valid), 32'd1);
          chk("hold_sum", 32'(bus.o_sum_voltage), 32'(sum_p));
          chk("hold_sat", 32'(bus.o_sat), 32'(sat_p));
        end
        if (bus.o_valid && bus.i_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_output: sum %0d delivered with nothing pending",
                     bus.o_sum_voltage);
          end else begin
            e = exp_q.pop_front();
            chk("o_sum_voltage", 32'(bus.o_sum_voltage), 32'(e[W-1:0]));
            chk("o_sat", 32'(bus.o_sat), 32'(e[W]));
            if (e[W] && model_cnt != {CNT_W{1'b1}}) model_cnt = model_cnt + 1'b1;
          end
        end
        hold_p = bus.o_valid && !bus.i_ready && !bus.i_clear;
        sum_p  = bus.o_sum_voltage;
        sat_p  = bus.o_sat;
        if (bus.i_clear) begin
          exp_q.delete();
          model_cnt = '0;
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [N_CH*W-1:0] ramp;
    int guard;
    int seen;
    for (int k = 0; k < N_CH; k++) ramp[k*W +: W] = W'(10 * (k + 1));
    bus.i_clear = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_weighted_spikes = '0;
    bus.i_ch_mask = '0;
    bus.i_cond_decay = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.o_ready), 32'd1);
    @(posedge clk); #1;

    // All channels 100 plus decay 50, with exact latency.
    drive_set(mk_all(14'd100), 8'hFF, 14'd50, 14'd850, 1'b0);
    measure_lat("latency_first_set");
    idle(3);

    // Channel masking: lower four channels only, then none.
    drive_set(ramp, 8'h0F, 14'd0, 14'd100, 1'b0);
    drive_set(ramp, 8'h00, 14'd7, 14'd7, 1'b0);
    idle(8);

    // Ten back-to-back sets under 1,0,0 backpressure: sum = 8*(10i+1)+i.
    rdy_mode = 1'b1;
    for (int i = 0; i < 10; i++)
      drive_set(mk_all(W'(10 * i + 1)), 8'hFF, W'(i), W'(81 * i + 8), 1'b0);
    bus.i_valid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 80) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("stream_all_delivered", 32'(exp_q.size()), 32'd0);
    rdy_mode = 1'b0;
    idle(3);

    // Clear with the counter at 3 and six sets in flight.
    for (int i = 0; i < 3; i++) drive_set(mk_all(14'h3FFF), 8'hFF, 14'h3FFF, 14'h3FFF, 1'b1);
    idle(8);
    chk("count_before_clear", 32'(bus.o_sat_count), 32'd3);
    for (int i = 0; i < 6; i++) drive_set(mk_all(W'(i + 1)), 8'hFF, 14'd0, W'(8 * (i + 1)), 1'b0);
    bus.i_clear = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_weighted_spikes = mk_all(14'd5);
    @(posedge clk); #1;
    bus.i_clear = 1'b0;
    bus.i_valid = 1'b0;
    chk("clear_o_valid", 32'(bus.o_valid), 32'd0);
    chk("clear_count", 32'(bus.o_sat_count), 32'd0);
    drive_set(mk_all(14'd3), 8'hFF, 14'd1, 14'd25, 1'b0);
    measure_lat("latency_after_clear");
    idle(3);

    // Saturation counting, then pin the counter at its maximum.
    drive_set(mk_all(14'h3FFF), 8'hFF, 14'h3FFF, 14'h3FFF, 1'b1);
    idle(7);
    chk("count_one", 32'(bus.o_sat_count), 32'd1);
    for (int i = 0; i < 3; i++) drive_set(mk_all(14'h3FFF), 8'hFF, 14'h3FFF, 14'h3FFF, 1'b1);
    idle(8);
    chk("count_four", 32'(bus.o_sat_count), 32'd4);
    for (int i = 0; i < 65540; i++) drive_set(mk_all(14'h3FFF), 8'hFF, 14'h3FFF, 14'h3FFF, 1'b1);
    idle(8);
    chk("count_saturated", 32'(bus.o_sat_count), 32'd65535);

    // Reset with three sets in flight drops them all.
    for (int i = 0; i < 3; i++) drive_set(mk_all(W'(50 * (i + 1))), 8'hFF, 14'd0, W'(400 * (i + 1)), 1'b0);
    reset = 1'b0;
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("midreset_o_valid", 32'(bus.o_valid), 32'd0);
    chk("midreset_o_sum", 32'(bus.o_sum_voltage), 32'd0);
    chk("midreset_o_sat_count", 32'(bus.o_sat_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.o_valid) seen++;
    end
    chk("no_output_after_reset", 32'(seen), 32'd0);
    @(posedge clk); #1;
    drive_set(mk_all(14'd1), 8'hFF, 14'd2, 14'd10, 1'b0);
    measure_lat("latency_after_reset");
    idle(4);
    chk("queue_empty_end", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
